uart_tx_words: RTL and testbench

//  Parallel-to-serial UART transmitter for the MVM result path.
//  - Accepts one wide result bus (R*W_Y_OUT bits) per valid/ready handshake.
//  - Splits it into BITS_PER_WORD words and sends each word on tx as one fixed-length packet.
//  - Sits between the MVM output register and the tx pin (uo_out[0]).
//  - Mirror of the system's UART receive path, which assembles the K/X bus from the rx pin.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_tx_words.sv | 100 ++++++++++
 tb/tb_uart_tx_words.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive paths.
// Both directions frame packets the same way, so the line levels live here.
package uart_pkg;

   typedef enum logic {IDLE, SEND} tx_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   function automatic int calc_n_words(input int w_bus, input int bits_per_word);
      return w_bus / bits_per_word;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: emits a one-cycle tick on the last clock of every UART bit.
// While disabled the counter is held at zero, so each new packet starts on a clean bit boundary.
module uart_baud_tick #(
   parameter int CLOCKS_PER_PULSE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;

   logic [CNT_W-1:0] pulse_cnt;

   assign tick = en && (pulse_cnt == CNT_W'(CLOCKS_PER_PULSE - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse_cnt <= '0;
      end else if (!en || tick) begin
         pulse_cnt <= '0;
      end else begin
         pulse_cnt <= pulse_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_words.sv
// Serialises one wide result bus into N_WORDS back-to-back UART packets on tx.
// Word 0 (the LSBs of s_data) goes first; every packet is start, data LSB-first, then stop/pad ones.
module uart_tx_words
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = 4,
   parameter int BITS_PER_WORD    = 8,
   parameter int PACKET_SIZE      = 13,
   parameter int W_BUS            = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [W_BUS-1:0] s_data,
   output logic             tx,
   output logic             busy
);

   localparam int N_WORDS = calc_n_words(W_BUS, BITS_PER_WORD);
   localparam int BIT_W   = $clog2(PACKET_SIZE);
   localparam int WORD_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   if (W_BUS % BITS_PER_WORD != 0) begin : g_bad_bus_width
      $error("uart_tx_words: W_BUS must be a multiple of BITS_PER_WORD");
   end
   if (PACKET_SIZE < BITS_PER_WORD + 2) begin : g_bad_packet_size
      $error("uart_tx_words: PACKET_SIZE must leave room for start and stop bits");
   end

   tx_state_t           state;
   logic [BIT_W-1:0]    bit_cnt;
   logic [WORD_W-1:0]   word_cnt;
   logic [W_BUS-1:0]    shreg;
   logic                tx_q;
   logic                tick;

   assign s_ready = (state == IDLE);
   assign busy    = (state == SEND);
   assign tx      = tx_q;

   uart_baud_tick #(
      .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE)
   ) u_baud_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state == SEND),
      .tick (tick)
   );

   // tx is loaded one bit ahead: on each tick it takes the level of the bit that starts next.
   // Words sit contiguously in shreg, so one right shift per data bit walks through all of them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         word_cnt <= '0;
         shreg    <= '0;
         tx_q     <= STOP_BIT;
      end else begin
         case (state)
            IDLE: begin
               tx_q     <= STOP_BIT;
               bit_cnt  <= '0;
               word_cnt <= '0;
               if (s_valid) begin
                  shreg <= s_data;
                  tx_q  <= START_BIT;
                  state <= SEND;
               end
            end
            SEND: begin
               if (tick) begin
                  if (bit_cnt == BIT_W'(PACKET_SIZE - 1)) begin
                     bit_cnt <= '0;
                     if (word_cnt == WORD_W'(N_WORDS - 1)) begin
                        word_cnt <= '0;
                        tx_q     <= STOP_BIT;
                        state    <= IDLE;
                     end else begin
                        word_cnt <= word_cnt + WORD_W'(1);
                        tx_q     <= START_BIT;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     if (bit_cnt < BIT_W'(BITS_PER_WORD)) begin
                        tx_q  <= shreg[0];
                        shreg <= shreg >> 1;
                     end else begin
                        tx_q <= STOP_BIT;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_words.sv
// Bench for uart_tx_words: directed buses are queued as expected words; a mid-bit
// sampling monitor decodes tx independently and checks each packet against the queue.
module tb_uart_tx_words;

   localparam int CPP = 4;
   localparam int BPW = 8;
   localparam int PS  = 13;
   localparam int WB  = 64;
   localparam int NW  = WB / BPW;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [WB-1:0] s_data;
   logic          tx;
   logic          busy;

   logic [BPW-1:0] exp_q[$];
   int             n_checks = 0;
   int             n_errors = 0;
   logic [PS-1:0]  pkt;

   uart_tx_words #(
      .CLOCKS_PER_PULSE (CPP),
      .BITS_PER_WORD    (BPW),
      .PACKET_SIZE      (PS),
      .W_BUS            (WB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .tx      (tx),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_words(input logic [WB-1:0] d);
      for (int i = 0; i < NW; i++) exp_q.push_back(d[i*BPW +: BPW]);
   endtask

   task automatic wait_ready(input int budget);
      int n;
      n = 0;
      while (!s_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_ready", 64'(s_ready), 64'd1);
   endtask

   // Called at a negedge; returns just after the handshake edge.
   task automatic send_bus(input logic [WB-1:0] d);
      wait_ready(1000);
      s_data  = d;
      s_valid = 1'b1;
      @(posedge clk);
      push_words(d);
      #1 s_valid = 1'b0;
   endtask

   task automatic mon_wait(input int n, output bit aborted);
      aborted = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (rst) aborted = 1'b1;
      end
   endtask

   // Monitor: detect the first cycle of a start bit, then sample each bit at its middle cycle.
   initial begin : monitor
      logic [BPW-1:0] w;
      logic [BPW-1:0] e;
      bit             ab;
      w = '0;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            mon_wait(2, ab);
            if (!ab) begin
               check("start_bit", 64'(tx), 64'd0);
               for (int j = 1; j < PS && !ab; j++) begin
                  mon_wait(CPP, ab);
                  if (!ab) begin
                     if (j <= BPW) w[j-1] = tx;
                     else check("stop_pad_bit", 64'(tx), 64'd1);
                     if (j == BPW) begin
                        if (exp_q.size() == 0) begin
                           n_checks++;
                           n_errors++;
                           $display("FAIL unexpected_word: got %0h expected none", w);
                        end else begin
                           e = exp_q.pop_front();
                           check("word", 64'(w), 64'(e));
                        end
                     end
                  end
               end
               if (!ab) mon_wait(1, ab);
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int busy_cnt;
      int n;

      // 1: reset held with s_valid high
      rst     = 1'b1;
      s_valid = 1'b1;
      s_data  = '1;
      repeat (3) begin
         @(negedge clk);
         check("rst_tx", 64'(tx), 64'd1);
         check("rst_s_ready", 64'(s_ready), 64'd1);
         check("rst_busy", 64'(busy), 64'd0);
      end
      s_valid = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'd0);

      // 2: first packet bit-by-bit and busy length
      pkt = {4'hF, 8'hEF, 1'b0};
      send_bus(64'h0123_4567_89AB_CDEF);
      busy_cnt = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (!busy) break;
         if (c < PS * CPP) check("first_packet_bit", 64'(tx), 64'(pkt[c/CPP]));
         busy_cnt++;
      end
      check("busy_cycles", 64'(busy_cnt), 64'd416);

      // 3: s_valid held high across two buses
      wait_ready(1000);
      s_data  = 64'hDEAD_BEEF_0BAD_F00D;
      s_valid = 1'b1;
      @(posedge clk);
      push_words(64'hDEAD_BEEF_0BAD_F00D);
      #1 s_data = 64'h3C3C_C3C3_9669_6996;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("second_ready", 64'(s_ready), 64'd1);
      check("idle_gap_tx", 64'(tx), 64'd1);
      @(posedge clk);
      push_words(64'h3C3C_C3C3_9669_6996);
      #1;
      check("second_accept_busy", 64'(busy), 64'd1);
      s_valid = 1'b0;

      // 4: inputs toggled randomly while busy
      @(negedge clk);
      send_bus(64'h5555_AAAA_0F0F_F0F0);
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (!busy) begin
            s_valid = 1'b0;
            break;
         end
         s_data  = {$urandom, $urandom};
         s_valid = 1'($urandom_range(0, 1));
      end

      // 5: reset 50 cycles into a transfer
      send_bus(64'h1122_3344_5566_7788);
      repeat (50) @(posedge clk);
      #1 check("pre_rst_busy", 64'(busy), 64'd1);
      #1 rst = 1'b1;
      #1;
      check("midrst_tx", 64'(tx), 64'd1);
      check("midrst_s_ready", 64'(s_ready), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("after_rst_tx", 64'(tx), 64'd1);
      send_bus(64'hFFFF_0000_A5A5_5A5A);

      // 6: all-zero and all-one buses
      @(negedge clk);
      send_bus(64'h0);
      @(negedge clk);
      send_bus({WB{1'b1}});

      @(negedge clk);
      for (int c = 0; c < 3000; c++) begin
         if (exp_q.size() == 0 && s_ready) break;
         @(negedge clk);
      end
      repeat (5) @(negedge clk);
      check("leftover_words", 64'(exp_q.size()), 64'd0);
      check("final_tx_idle", 64'(tx), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
